deserializer_10to50: RTL and testbench

Receive-side counterpart of the 50-to-10 serializer. Accepts one 10-bit slice per clock plus the serializer's `sync` marker, which is high on the cycle carrying the last slice, bits [49:40]. Reassembles the 50-bit word. Tracks frame alignment with a hunt/acquire/lock state machine, emits each word with a one-cycle valid strobe, and flags misaligned `sync`.

---
 rtl/deser_pkg.sv | 16 +
 rtl/deserializer_10to50_if.sv | 23 ++
 rtl/deser_lock_fsm.sv | 116 +++++++++++
 rtl/deserializer_10to50.sv | 86 ++++++++
 tb/tb_deserializer_10to50.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the 10-to-50 deserializer.
package deser_pkg;

    localparam int SLICE_W = 10;
    localparam int SLICES  = 5;
    localparam int WORD_W  = 50;
    localparam int CNT_W   = 3;   // holds slice index 0..4
    localparam int GOOD_W  = 4;   // holds good-frame count 0..14

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } deser_state_e;

endpackage

// File: rtl/deserializer_10to50_if.sv
// Slice input / word output bundle of the deserializer.
// master: the serializer-side driver; slave: the deserializer itself.
interface deserializer_10to50_if;

    logic [deser_pkg::SLICE_W-1:0] in_data;
    logic                          in_sync;
    logic [deser_pkg::WORD_W-1:0]  out_data;
    logic                          out_valid;
    logic                          locked;
    logic                          err;
    logic [7:0]                    err_cnt;

    modport master (
        output in_data, in_sync,
        input  out_data, out_valid, locked, err, err_cnt
    );

    modport slave (
        input  in_data, in_sync,
        output out_data, out_valid, locked, err, err_cnt
    );

endinterface

// File: rtl/deser_lock_fsm.sv
// Frame alignment tracker: hunt for a sync, count LOCK_WORDS clean frames,
// then stay locked until an early or missing sync. Emits a one-bit emit
// request on the sample carrying the last slice of a word to be output.
module deser_lock_fsm
    import deser_pkg::*;
#(
    parameter int LOCK_WORDS = 2  // 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_sync_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             capture_o,
    output logic             emit_o,
    output logic             err_o,
    output logic             locked_o
);

    localparam logic [GOOD_W-1:0] LAST_GOOD = GOOD_W'(LOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLICES - 1);

    deser_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              err_q, err_d;

    logic good_end, early_sync, missing_sync;

    assign good_end     =  in_sync_i && (cnt_q == CNT_LAST);
    assign early_sync   =  in_sync_i && (cnt_q != CNT_LAST);
    assign missing_sync = !in_sync_i && (cnt_q == CNT_LAST);

    // State, slice counter, good-frame counter and registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            good_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            err_q   <= err_d;
        end
    end

    // Next-state: alignment decisions based on where the sync lands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        unique case (state_q)
            HUNT: begin
                if (in_sync_i) begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (good_end) begin
                    cnt_d = '0;
                    if (good_q == LAST_GOOD) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end else if (early_sync) begin
                    cnt_d  = '0;
                    good_d = '0;
                end else if (missing_sync) begin
                    state_d = HUNT;
                    cnt_d   = '0;
                    good_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (good_end) begin
                    cnt_d = '0;
                end else if (early_sync) begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                    good_d  = '0;
                end else if (missing_sync) begin
                    state_d = HUNT;
                    cnt_d   = '0;
                    good_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = HUNT;
                cnt_d   = '0;
                good_d  = '0;
            end
        endcase
    end

    // Outputs: emit on a good end that is (or completes) lock; error only when locked.
    always_comb begin
        capture_o = (state_q != HUNT);
        emit_o    = good_end && ((state_q == LOCKED) ||
                                 ((state_q == ACQUIRE) && (good_q == LAST_GOOD)));
        err_d     = (state_q == LOCKED) && (early_sync || missing_sync);
    end

    assign cnt_o    = cnt_q;
    assign err_o    = err_q;
    assign locked_o = (state_q == LOCKED);

endmodule

// File: rtl/deserializer_10to50.sv
// 10-bit slice to 50-bit word deserializer with frame-lock tracking.
// Optional feature macro: DESER_ERRCNT_EN enables the saturating error
// counter on err_cnt; without it err_cnt is tied to zero.
module deserializer_10to50
    import deser_pkg::*;
#(
    parameter int LOCK_WORDS = 2  // 1..15
) (
    input  logic                  clk,
    input  logic                  rst,
    deserializer_10to50_if.slave  bus_if
);

    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             emit;
    logic             err;
    logic             locked;

    logic [SLICES-2:0][SLICE_W-1:0] slot_q, slot_d;
    logic [WORD_W-1:0]              out_data_q, out_data_d;
    logic                           out_valid_q;

    deser_lock_fsm #(
        .LOCK_WORDS (LOCK_WORDS)
    ) u_lock_fsm (
        .clk       (clk),
        .rst       (rst),
        .in_sync_i (bus_if.in_sync),
        .cnt_o     (cnt),
        .capture_o (capture),
        .emit_o    (emit),
        .err_o     (err),
        .locked_o  (locked)
    );

    // Slot write: slices 0..3 land in their slot; slice 4 goes straight to the output.
    always_comb begin
        slot_d = slot_q;
        if (capture && !cnt[2]) begin
            slot_d[cnt[1:0]] = bus_if.in_data;
        end
        out_data_d = emit ? {bus_if.in_data, slot_q} : out_data_q;
    end

    // Slot and output registers; the output word holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            out_data_q  <= out_data_d;
            out_valid_q <= emit;
        end
    end

`ifdef DESER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating error counter, advanced by each registered err pulse.
    always_comb begin
        err_cnt_d = (err && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Error counter register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus_if.err_cnt = err_cnt_q;
`else
    assign bus_if.err_cnt = 8'd0;
`endif

    assign bus_if.out_data  = out_data_q;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.locked    = locked;
    assign bus_if.err       = err;

endmodule

// File: tb/tb_deserializer_10to50.sv
// Randomized bench for deserializer_10to50 against a queue-based frame model.
module tb_deserializer_10to50;

    localparam int LOCK_WORDS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    deserializer_10to50_if bus_if();

    deserializer_10to50 #(
        .LOCK_WORDS (LOCK_WORDS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int vcnt   = 0;

    // reference model state
    bit          m_aligned = 1'b0;
    bit          m_lk      = 1'b0;
    int          m_run     = 0;
    logic [9:0]  m_q[$];
    logic [49:0] e_data    = '0;
    logic        e_valid   = 1'b0;
    logic        e_err     = 1'b0;
    logic        e_locked  = 1'b0;
    int          e_cnt     = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the last four slices since a sync plus a sync-carrying slice form a word.
    task automatic model(input logic [9:0] d, input logic s, input logic r);
        logic [49:0] w;
        if (r) begin
            m_aligned = 1'b0; m_lk = 1'b0; m_run = 0; m_q.delete();
            e_data = '0; e_valid = 1'b0; e_err = 1'b0; e_cnt = 0;
        end else begin
`ifdef DESER_ERRCNT_EN
            if (e_err && e_cnt < 255) e_cnt++;
`endif
            e_valid = 1'b0;
            e_err   = 1'b0;
            if (!m_aligned) begin
                if (s) begin
                    m_aligned = 1'b1; m_run = 0; m_q.delete();
                end
            end else if (s) begin
                if (m_q.size() == 4) begin
                    w = 50'(d) << 40;
                    for (int k = 0; k < 4; k++) w = w + (50'(m_q[k]) << (10 * k));
                    if (m_lk) begin
                        e_valid = 1'b1; e_data = w;
                    end else begin
                        m_run++;
                        if (m_run == LOCK_WORDS) begin
                            m_lk = 1'b1; m_run = 0; e_valid = 1'b1; e_data = w;
                        end
                    end
                end else begin
                    if (m_lk) e_err = 1'b1;
                    m_lk = 1'b0; m_run = 0;
                end
                m_q.delete();
            end else if (m_q.size() == 4) begin
                if (m_lk) e_err = 1'b1;
                m_lk = 1'b0; m_aligned = 1'b0; m_run = 0; m_q.delete();
            end else begin
                m_q.push_back(d);
            end
        end
        e_locked = m_lk;
    endtask

    // One clock: check outputs from the previous edge, then drive the next sample.
    task automatic step(input logic [9:0] d, input logic s, input logic r);
        @(negedge clk);
        chk_eq("out_valid", 64'(bus_if.out_valid), 64'(e_valid));
        chk_eq("err",       64'(bus_if.err),       64'(e_err));
        chk_eq("locked",    64'(bus_if.locked),    64'(e_locked));
        chk_eq("out_data",  64'(bus_if.out_data),  64'(e_data));
        chk_eq("err_cnt",   64'(bus_if.err_cnt),   64'(e_cnt));
        if (bus_if.out_valid === 1'b1) vcnt++;
        bus_if.in_data = d;
        bus_if.in_sync = s;
        rst            = r;
        model(d, s, r);
    endtask

    task automatic send_frame(input logic [49:0] word);
        for (int k = 0; k < 5; k++) step(word[10*k +: 10], k == 4, 1'b0);
    endtask

    // n slices of a word, sync on the last one (early sync when n < 5).
    task automatic send_partial(input logic [49:0] word, input int n);
        for (int k = 0; k < n; k++) step(word[10*k +: 10], k == n - 1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(10'($urandom), 1'b0, 1'b0);
    endtask

    function automatic logic [49:0] rand_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[49:0];
    endfunction

    initial begin
        logic [49:0] w;
        int          sel;
        bus_if.in_data = '0;
        bus_if.in_sync = 1'b0;

        // reset
        step(10'd0, 1'b0, 1'b1);
        step(10'd0, 1'b0, 1'b1);

        // loopback lock with a fixed word
        vcnt = 0;
        w = 50'h2_4E6E_5174_FC53;
        for (int f = 0; f < 6; f++) send_frame(w);

        // incrementing words, already locked
        for (int f = 0; f < 8; f++) send_frame(50'(5 * f));
        chk_eq("valid_count", 64'(vcnt), 64'd11);

        // early sync while locked, then relock
        send_partial(rand_word(), 3);
        for (int f = 0; f < 3; f++) send_frame(rand_word());

        // missing sync for 12 cycles, then resync
        idle(12);
        for (int f = 0; f < 4; f++) send_frame(rand_word());

        // reset mid-frame while locked
        send_partial(rand_word(), 0);
        for (int k = 0; k < 3; k++) step(10'($urandom), 1'b0, 1'b0);
        step(10'($urandom), 1'b0, 1'b1);
        for (int f = 0; f < 4; f++) send_frame(rand_word());

        // random mix of clean frames and alignment faults
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      send_partial(rand_word(), int'($urandom_range(1, 4)));
            else if (sel == 1) idle(int'($urandom_range(3, 12)));
            else if (sel == 2) begin
                for (int k = 0; k < 3; k++) step(10'($urandom), 1'b0, 1'b0);
                step(10'($urandom), 1'b0, 1'b1);
            end else           send_frame(rand_word());
        end

        // fresh start, then 300 early syncs, each followed by relock
        step(10'd0, 1'b0, 1'b1);
        for (int f = 0; f < 3; f++) send_frame(rand_word());
        for (int i = 0; i < 300; i++) begin
            send_partial(rand_word(), 3);
            send_frame(rand_word());
            send_frame(rand_word());
        end
        send_frame(rand_word());
        step(10'd0, 1'b0, 1'b0);
        step(10'd1, 1'b0, 1'b0);
`ifdef DESER_ERRCNT_EN
        chk_eq("err_cnt_sat", 64'(bus_if.err_cnt), 64'd255);
`else
        chk_eq("err_cnt_off", 64'(bus_if.err_cnt), 64'd0);
`endif
        chk_eq("final_locked", 64'(bus_if.locked), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
